// File: rtl/imem_boot_loader.sv
// imem_boot_loader: packs a length-prefixed byte stream into 32-bit words, writes them to i_mem and stalls the CPU until the load completes
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  run,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  fetch_readEnable,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  mem_readEnable,
  output logic [ADDR_WIDTH-1:0] mem_readAddress,
  output logic                  mem_writeEnable,
  output logic [ADDR_WIDTH-1:0] mem_writeAddress,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_error
);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH / 4);
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR} state_t;
  state_t state, nxt;
  logic [15:0] len, word_cnt, len_n;
  logic [1:0] byte_cnt;
  logic [DATA_WIDTH-1:0] asm_word, asm_next;
  logic accept;
  assign accept = rx_valid && rx_ready;
  assign len_n = {len[15:8], rx_data};
  assign asm_next = {asm_word[DATA_WIDTH-9:0], rx_data};
  assign mem_readEnable = fetch_readEnable && !cpu_stall;
  assign mem_readAddress = fetch_address;
  // next-state decode; start has priority over run in IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = start ? LEN_HI : run ? DONE : IDLE;
      LEN_HI: nxt = accept ? LEN_LO : LEN_HI;
      LEN_LO: nxt = !accept ? LEN_LO : len_n == 16'd0 ? DONE : {1'b0, len_n} > MAX_WORDS ? ERROR : DATA;
      DATA:   nxt = (accept && byte_cnt == 2'd3) ? WRITE : DATA;
      WRITE:  nxt = (word_cnt + 16'd1 == len) ? DONE : DATA;
      DONE:   nxt = start ? LEN_HI : DONE;
      ERROR:  nxt = start ? LEN_HI : ERROR;
      default: nxt = IDLE;
    endcase
  end
  // state, datapath and registered outputs decoded from the upcoming state
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      len <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      rx_ready <= 1'b0;
      mem_writeEnable <= 1'b0;
      mem_writeAddress <= '0;
      mem_writeData <= '0;
      cpu_stall <= 1'b1;
      load_done <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state <= nxt;
      rx_ready <= nxt == LEN_HI || nxt == LEN_LO || nxt == DATA;
      mem_writeEnable <= nxt == WRITE;
      cpu_stall <= nxt != DONE;
      load_done <= nxt == DONE;
      load_error <= nxt == ERROR;
      if (state == LEN_HI && accept) len[15:8] <= rx_data;
      if (state == LEN_LO && accept) begin
        len[7:0] <= rx_data;
        word_cnt <= '0;
        byte_cnt <= '0;
        mem_writeAddress <= '0;
      end
      if (state == DATA && accept) begin
        asm_word <= asm_next;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          mem_writeData <= asm_next;
          mem_writeAddress <= {word_cnt[ADDR_WIDTH-3:0], 2'b00};
        end
      end
      if (state == WRITE) word_cnt <= word_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven cycle vectors plus directed multi-cycle load sequences
module tb_imem_boot_loader;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, run = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic fetch_readEnable = 1'b0;
  logic [11:0] fetch_address = '0;
  logic rx_ready, mem_readEnable, mem_writeEnable, cpu_stall, load_done, load_error;
  logic [11:0] mem_readAddress, mem_writeAddress;
  logic [31:0] mem_writeData;
  int n_cmp = 0, n_bad = 0, nv = 0;

  imem_boot_loader dut (
    .clock(clock), .reset(reset), .start(start), .run(run), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .fetch_readEnable(fetch_readEnable), .fetch_address(fetch_address),
    .mem_readEnable(mem_readEnable), .mem_readAddress(mem_readAddress), .mem_writeEnable(mem_writeEnable),
    .mem_writeAddress(mem_writeAddress), .mem_writeData(mem_writeData), .cpu_stall(cpu_stall),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic st, rn, rv; logic [7:0] rd; logic fre; logic [11:0] fa;
    logic rdy, we; logic [11:0] wa; logic [31:0] wd; logic stall, done, err, re;
  } vec_t;
  vec_t vecs[32];

  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  wr_t wr_q[$];

  // record every write pulse seen by memory
  always @(negedge clock) if (mem_writeEnable === 1'b1) wr_q.push_back('{mem_writeAddress, mem_writeData});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, rn, rv, input logic [7:0] rd, input logic fre, input logic [11:0] fa,
                     input logic rdy, we, input logic [11:0] wa, input logic [31:0] wd,
                     input logic stall, done, err, re);
    vecs[nv] = '{st, rn, rv, rd, fre, fa, rdy, we, wa, wd, stall, done, err, re};
    nv++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    logic r;
    repeat (gap) begin @(negedge clock); rx_valid = 1'b0; end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    forever begin
      r = rx_ready;
      @(posedge clock);
      if (r) break;
      n++;
      if (n > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout actual=no_accept required=accept byte=%h", b);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    @(negedge clock);
    rx_valid = 1'b0;
    while (load_done !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    chk(nm, 32'(load_done), 32'd1);
  endtask

  initial begin
    logic [31:0] w3[3];
    logic [31:0] wd;
    int bad;
    w3[0] = 32'h11223344; w3[1] = 32'h55667788; w3[2] = 32'h99AABBCC;
    //   st rn rv rd    fre fa      rdy we wa      wd            stl dn er re
    add(0, 1, 0, 8'h00, 0, 12'h010, 0, 0, 12'h000, 32'h0,        0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 1, 12'h010, 0, 0, 12'h000, 32'h0,        0, 1, 0, 1);
    add(1, 0, 0, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h02, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'hDE, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'hAD, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'hBE, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'hEF, 1, 12'h010, 0, 1, 12'h000, 32'hDEADBEEF, 1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h010, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h13, 1, 12'h010, 0, 1, 12'h004, 32'h00000013, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 1, 12'h3FC, 0, 0, 12'h000, 32'h0,        0, 1, 0, 1);
    add(1, 0, 0, 8'h00, 1, 12'h3FC, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h04, 1, 12'h3FC, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h01, 1, 12'h3FC, 0, 0, 12'h000, 32'h0,        1, 0, 1, 0);
    add(0, 0, 1, 8'h55, 1, 12'h3FC, 0, 0, 12'h000, 32'h0,        1, 0, 1, 0);
    add(1, 0, 0, 8'h00, 1, 12'h3FC, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h3FC, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h3FC, 0, 0, 12'h000, 32'h0,        0, 1, 0, 1);
    add(0, 0, 0, 8'h00, 0, 12'h3FC, 0, 0, 12'h000, 32'h0,        0, 1, 0, 0);
    add(1, 0, 0, 8'h00, 1, 12'h020, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h04, 1, 12'h020, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(0, 0, 1, 8'h00, 1, 12'h020, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);
    add(1, 0, 0, 8'h00, 1, 12'h020, 1, 0, 12'h000, 32'h0,        1, 0, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_writeEnable), 32'd0);
    chk("rst_wa", 32'(mem_writeAddress), 32'd0);
    chk("rst_wd", mem_writeData, 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(negedge clock);
      start = vecs[i].st; run = vecs[i].rn; rx_valid = vecs[i].rv; rx_data = vecs[i].rd;
      fetch_readEnable = vecs[i].fre; fetch_address = vecs[i].fa;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_we", i), 32'(mem_writeEnable), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_wa", i), 32'(mem_writeAddress), 32'(vecs[i].wa));
        chk($sformatf("v%0d_wd", i), mem_writeData, vecs[i].wd);
      end
      chk($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d_done", i), 32'(load_done), 32'(vecs[i].done));
      chk($sformatf("v%0d_err", i), 32'(load_error), 32'(vecs[i].err));
      chk($sformatf("v%0d_re", i), 32'(mem_readEnable), 32'(vecs[i].re));
      chk($sformatf("v%0d_ra", i), 32'(mem_readAddress), 32'(vecs[i].fa));
    end
    @(negedge clock);
    start = 1'b0; run = 1'b0; rx_valid = 1'b0; fetch_readEnable = 1'b0;
    wr_q.delete();

    // full-capacity load continuing from the N=1024 header above
    for (int w = 0; w < 1024; w++) begin
      wd = 32'hA5000000 | 32'(w);
      for (int b = 3; b >= 0; b--) send(wd[b*8 +: 8], 0);
    end
    wait_done("full_done");
    chk("full_count", 32'(wr_q.size()), 32'd1024);
    bad = 0;
    foreach (wr_q[k]) if (wr_q[k].a !== 12'(k * 4) || wr_q[k].d !== (32'hA5000000 | 32'(k))) bad++;
    chk("full_contents_bad", 32'(bad), 32'd0);
    if (wr_q.size() == 1024) chk("full_last_addr", 32'(wr_q[1023].a), 32'hFFC);

    // N=3 with random rx_valid gaps; the first byte of each word after the first is held across WRITE
    wr_q.delete();
    pulse_start();
    send(8'h00, $urandom_range(0, 2));
    send(8'h03, $urandom_range(0, 2));
    for (int i = 0; i < 12; i++) send(w3[i / 4][(3 - i % 4) * 8 +: 8], (i % 4 == 0) ? 0 : $urandom_range(0, 3));
    wait_done("gap_done");
    chk("gap_count", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
      chk($sformatf("gap_addr%0d", i), 32'(wr_q[i].a), 32'(i * 4));
      chk($sformatf("gap_data%0d", i), wr_q[i].d, w3[i]);
    end

    // reset after two payload bytes discards the partial word
    wr_q.delete();
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'hAA, 1); send(8'hBB, 0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_stall", 32'(cpu_stall), 32'd1);
    chk("mid_rst_done", 32'(load_done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_rst_idle_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_no_write", 32'(wr_q.size()), 32'd0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hCA, 0); send(8'hFE, 2); send(8'hBA, 0); send(8'hBE, 1);
    wait_done("reload_done");
    chk("reload_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      chk("reload_addr", 32'(wr_q[0].a), 32'd0);
      chk("reload_data", wr_q[0].d, 32'hCAFEBABE);
    end
    chk("reload_stall", 32'(cpu_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
